// File: rtl/ipfilter_regfile.sv
// ipfilter_regfile: AXI-Lite register file for the TX/RX IPv4 filter tables and drop counters.
// Optional macro IPFILTER_SHADOW_COMMIT_EN: entry writes land in shadow copies published by COMMIT.
module ipfilter_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 24,
  parameter int NUM_ENTRIES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr_i,
  input  logic [2:0]                s_axil_awprot_i,
  input  logic                      s_axil_awvalid_i,
  output logic                      s_axil_awready_o,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb_i,
  input  logic                      s_axil_wvalid_i,
  output logic                      s_axil_wready_o,
  output logic [1:0]                s_axil_bresp_o,
  output logic                      s_axil_bvalid_o,
  input  logic                      s_axil_bready_i,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr_i,
  input  logic [2:0]                s_axil_arprot_i,
  input  logic                      s_axil_arvalid_i,
  output logic                      s_axil_arready_o,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata_o,
  output logic [1:0]                s_axil_rresp_o,
  output logic                      s_axil_rvalid_o,
  input  logic                      s_axil_rready_i,
  output logic [NUM_ENTRIES-1:0]    tx_vld_o,
  output logic [NUM_ENTRIES-1:0]    rx_vld_o,
  output logic [32*NUM_ENTRIES-1:0] tx_ipv4_addr_o,
  output logic [32*NUM_ENTRIES-1:0] tx_ipv4_netmask_o,
  output logic [32*NUM_ENTRIES-1:0] rx_ipv4_addr_o,
  output logic [32*NUM_ENTRIES-1:0] rx_ipv4_netmask_o,
  input  logic [31:0]               tx_drop_cnt_i,
  input  logic [31:0]               rx_drop_cnt_i
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int NE2 = 2 * NUM_ENTRIES;
  localparam int IW  = $clog2(NE2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ipfilter_regfile: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 12) begin : g_bad_addr_width
    $error("ipfilter_regfile: ADDR_WIDTH must be at least 12");
  end
  if (NUM_ENTRIES < 1 || NUM_ENTRIES > 64) begin : g_bad_num_entries
    $error("ipfilter_regfile: NUM_ENTRIES must be 1..64");
  end

  typedef enum logic [2:0] {R_NONE, R_ENT, R_TXD, R_RXD, R_COMMIT, R_INFO} reg_e;
  typedef struct packed {
    reg_e       kind;
    logic       rx;
    logic [5:0] idx;
    logic [1:0] fld;
  } dec_t;

  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    dec_t       d;
    logic [9:0] off;
    off    = a[11:2];
    d.kind = R_NONE;
    d.rx   = off[8];
    d.idx  = off[7:2];
    d.fld  = off[1:0];
    if ((a >> 12) != {ADDR_WIDTH{1'b0}}) begin
      d.kind = R_NONE;
    end else begin
      case (off[9:8])
        2'b00, 2'b01: begin
          if (off[1:0] != 2'b11 && {26'd0, off[7:2]} < 32'(NUM_ENTRIES)) begin
            d.kind = R_ENT;
          end else begin
            d.kind = R_NONE;
          end
        end
        2'b10: begin
          case (off[7:0])
            8'h00:   d.kind = R_TXD;
            8'h01:   d.kind = R_RXD;
            8'h04:   d.kind = R_COMMIT;
            8'h07:   d.kind = R_INFO;
            default: d.kind = R_NONE;
          endcase
        end
        default: d.kind = R_NONE;
      endcase
    end
    return d;
  endfunction

  function automatic logic [IW-1:0] ent_index(input dec_t d);
    return IW'(d.rx ? (7'(d.idx) + 7'(NUM_ENTRIES)) : 7'(d.idx));
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [SW-1:0] strb);
    logic [31:0] r;
    for (int b = 0; b < SW; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  // Write channel state
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  // Read channel state
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]           tx_drop_q, rx_drop_q;

  logic act_vld_q [NE2];
  logic act_vld_d [NE2];
  logic [31:0] act_addr_q [NE2];
  logic [31:0] act_addr_d [NE2];
  logic [31:0] act_mask_q [NE2];
  logic [31:0] act_mask_d [NE2];
`ifdef IPFILTER_SHADOW_COMMIT_EN
  logic shd_vld_q [NE2];
  logic shd_vld_d [NE2];
  logic [31:0] shd_addr_q [NE2];
  logic [31:0] shd_addr_d [NE2];
  logic [31:0] shd_mask_q [NE2];
  logic [31:0] shd_mask_d [NE2];
`endif

  logic                  aw_hs_s, w_hs_s, ar_hs_s, wr_fire_s, wr_ok_s, rd_ok_s, commit_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [31:0]           wr_data_s, rd_word_s;
  logic [SW-1:0]         wr_strb_s;
  dec_t                  wr_dec_s, rd_dec_s;
  logic [IW-1:0]         wr_ent_s, rd_ent_s;
  logic                  unused_s;

  assign unused_s = ^{s_axil_awprot_i, s_axil_arprot_i, awaddr_q[1:0], s_axil_araddr_i[1:0]};

  assign s_axil_awready_o = !aw_held_q && !bvalid_q;
  assign s_axil_wready_o  = !w_held_q && !bvalid_q;
  assign s_axil_arready_o = !rvalid_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;

  assign aw_hs_s   = s_axil_awvalid_i && s_axil_awready_o;
  assign w_hs_s    = s_axil_wvalid_i && s_axil_wready_o;
  assign ar_hs_s   = s_axil_arvalid_i && s_axil_arready_o;
  assign wr_fire_s = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
  assign wr_addr_s = aw_held_q ? awaddr_q : s_axil_awaddr_i;
  assign wr_data_s = w_held_q ? wdata_q : s_axil_wdata_i;
  assign wr_strb_s = w_held_q ? wstrb_q : s_axil_wstrb_i;
  assign wr_dec_s  = decode(wr_addr_s);
  assign rd_dec_s  = decode(s_axil_araddr_i);
  assign wr_ent_s  = ent_index(wr_dec_s);
  assign rd_ent_s  = ent_index(rd_dec_s);
  assign wr_ok_s   = (wr_dec_s.kind == R_ENT) || (wr_dec_s.kind == R_COMMIT);
  assign rd_ok_s   = (rd_dec_s.kind == R_ENT) || (rd_dec_s.kind == R_TXD) ||
                     (rd_dec_s.kind == R_RXD) || (rd_dec_s.kind == R_INFO);
  assign commit_s  = wr_fire_s && (wr_dec_s.kind == R_COMMIT) && wr_data_s[0] && wr_strb_s[0];

  // Write channel: hold AW/W independently, complete once both are present
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_fire_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        awaddr_d  = s_axil_awaddr_i;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        wdata_d  = s_axil_wdata_i;
        wstrb_d  = s_axil_wstrb_i;
      end else begin
        w_held_d = w_held_q;
      end
      if (bvalid_q && s_axil_bready_i) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
  end

  // Entry next-state: direct update, or shadow update plus atomic commit
  always_comb begin
    act_vld_d  = act_vld_q;
    act_addr_d = act_addr_q;
    act_mask_d = act_mask_q;
`ifdef IPFILTER_SHADOW_COMMIT_EN
    shd_vld_d  = shd_vld_q;
    shd_addr_d = shd_addr_q;
    shd_mask_d = shd_mask_q;
    if (wr_fire_s && wr_dec_s.kind == R_ENT) begin
      case (wr_dec_s.fld)
        2'd0:    shd_vld_d[wr_ent_s] = wr_strb_s[0] ? wr_data_s[0] : shd_vld_q[wr_ent_s];
        2'd1:    shd_addr_d[wr_ent_s] = merge_bytes(shd_addr_q[wr_ent_s], wr_data_s, wr_strb_s);
        2'd2:    shd_mask_d[wr_ent_s] = merge_bytes(shd_mask_q[wr_ent_s], wr_data_s, wr_strb_s);
        default: shd_vld_d = shd_vld_q;
      endcase
    end else if (commit_s) begin
      act_vld_d  = shd_vld_q;
      act_addr_d = shd_addr_q;
      act_mask_d = shd_mask_q;
    end else begin
      act_vld_d = act_vld_q;
    end
`else
    if (wr_fire_s && wr_dec_s.kind == R_ENT) begin
      case (wr_dec_s.fld)
        2'd0:    act_vld_d[wr_ent_s] = wr_strb_s[0] ? wr_data_s[0] : act_vld_q[wr_ent_s];
        2'd1:    act_addr_d[wr_ent_s] = merge_bytes(act_addr_q[wr_ent_s], wr_data_s, wr_strb_s);
        2'd2:    act_mask_d[wr_ent_s] = merge_bytes(act_mask_q[wr_ent_s], wr_data_s, wr_strb_s);
        default: act_vld_d = act_vld_q;
      endcase
    end else begin
      act_vld_d = act_vld_q;
    end
`endif
  end

  // Read mux and read channel next-state; reads see pre-edge register values
  always_comb begin
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_word_s = 32'd0;
    case (rd_dec_s.kind)
      R_ENT: begin
        case (rd_dec_s.fld)
`ifdef IPFILTER_SHADOW_COMMIT_EN
          2'd0:    rd_word_s = {31'd0, shd_vld_q[rd_ent_s]};
          2'd1:    rd_word_s = shd_addr_q[rd_ent_s];
          2'd2:    rd_word_s = shd_mask_q[rd_ent_s];
`else
          2'd0:    rd_word_s = {31'd0, act_vld_q[rd_ent_s]};
          2'd1:    rd_word_s = act_addr_q[rd_ent_s];
          2'd2:    rd_word_s = act_mask_q[rd_ent_s];
`endif
          default: rd_word_s = 32'd0;
        endcase
      end
      R_TXD:   rd_word_s = tx_drop_q;
      R_RXD:   rd_word_s = rx_drop_q;
      R_INFO:  rd_word_s = {8'h02, 16'h0000, 8'(NUM_ENTRIES)};
      default: rd_word_s = 32'd0;
    endcase
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok_s ? rd_word_s : 32'd0;
      rresp_d  = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= 32'd0;
      wstrb_q    <= {SW{1'b0}};
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= {DATA_WIDTH{1'b0}};
      tx_drop_q  <= 32'd0;
      rx_drop_q  <= 32'd0;
      act_vld_q  <= '{default: 1'b0};
      act_addr_q <= '{default: 32'd0};
      act_mask_q <= '{default: 32'd0};
`ifdef IPFILTER_SHADOW_COMMIT_EN
      shd_vld_q  <= '{default: 1'b0};
      shd_addr_q <= '{default: 32'd0};
      shd_mask_q <= '{default: 32'd0};
`endif
    end else begin
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      tx_drop_q  <= tx_drop_cnt_i;
      rx_drop_q  <= rx_drop_cnt_i;
      act_vld_q  <= act_vld_d;
      act_addr_q <= act_addr_d;
      act_mask_q <= act_mask_d;
`ifdef IPFILTER_SHADOW_COMMIT_EN
      shd_vld_q  <= shd_vld_d;
      shd_addr_q <= shd_addr_d;
      shd_mask_q <= shd_mask_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_out
    assign tx_vld_o[i]                    = act_vld_q[i];
    assign rx_vld_o[i]                    = act_vld_q[i + NUM_ENTRIES];
    assign tx_ipv4_addr_o[32*i +: 32]    = act_addr_q[i];
    assign tx_ipv4_netmask_o[32*i +: 32] = act_mask_q[i];
    assign rx_ipv4_addr_o[32*i +: 32]    = act_addr_q[i + NUM_ENTRIES];
    assign rx_ipv4_netmask_o[32*i +: 32] = act_mask_q[i + NUM_ENTRIES];
  end

endmodule

// File: tb/tb_ipfilter_regfile.sv
// tb_ipfilter_regfile: scoreboard bench for ipfilter_regfile (default 16 entries, 24-bit address).
module tb_ipfilter_regfile;
  localparam int NE = 16;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NE-1:0] tx_vld, rx_vld;
  logic [32*NE-1:0] tx_addr, tx_mask, rx_addr, rx_mask;
  logic [31:0]   tx_drop, rx_drop;

  int total = 0;
  int bad = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t      rd_q[$];
  logic [1:0] wr_q[$];

  ipfilter_regfile dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .tx_vld_o(tx_vld), .rx_vld_o(rx_vld),
    .tx_ipv4_addr_o(tx_addr), .tx_ipv4_netmask_o(tx_mask),
    .rx_ipv4_addr_o(rx_addr), .rx_ipv4_netmask_o(rx_mask),
    .tx_drop_cnt_i(tx_drop), .rx_drop_cnt_i(rx_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp);
    int n;
    logic aw_ok, w_ok;
    logic [1:0] e;
    wr_q.push_back(resp);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_ok = awready; w_ok = wready;
      step();
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      step();
      n++;
    end
    e = wr_q.pop_front();
    total++;
    if (bvalid !== 1'b1 || bresp !== e) begin
      bad++;
      $display("FAIL wr_resp addr=%h got bvalid=%b bresp=%b want bvalid=1 bresp=%b", a, bvalid, bresp, e);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [23:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n;
    logic ok;
    rexp_t e;
    rd_q.push_back('{data: d, resp: resp});
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin
      ok = arready;
      step();
      n++;
    end while (!ok && n < 20);
    arvalid = 1'b0;
    e = rd_q.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
      bad++;
      $display("FAIL rd addr=%h got rvalid=%b rdata=%h rresp=%b want rdata=%h rresp=%b",
               a, rvalid, rdata, rresp, e.data, e.resp);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if ({bvalid, rvalid} !== 2'b00 || rdata !== 32'd0 ||
        |{tx_vld, rx_vld, tx_addr, tx_mask, rx_addr, rx_mask} !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got bvalid=%b rvalid=%b rdata=%h want all zero", bvalid, rvalid, rdata);
    end
    rst = 1'b0;
    step();
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_ready got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_split_write();
    logic [1:0] e;
    wr_q.push_back(OK);
    awaddr = 24'h000004; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b1) begin
        bad++;
        $display("FAIL split_wait cyc=%0d got bvalid=%b awready=%b wready=%b want 0 0 1",
                 i, bvalid, awready, wready);
      end
      if (i < 2) step();
    end
    wdata = 32'hC0A80001; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    e = wr_q.pop_front();
    total++;
    if (bvalid !== 1'b1 || bresp !== e) begin
      bad++;
      $display("FAIL split_bvalid got bvalid=%b bresp=%b want 1 %b", bvalid, bresp, e);
    end
`ifndef IPFILTER_SHADOW_COMMIT_EN
    total++;
    if (tx_addr[31:0] !== 32'hC0A80001) begin
      bad++;
      $display("FAIL split_output got %h want c0a80001", tx_addr[31:0]);
    end
`endif
    bready = 1'b1;
    step();
    bready = 1'b0;
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      bad++;
      $display("FAIL split_bclear got bvalid=%b awready=%b want 0 1", bvalid, awready);
    end
    axi_read(24'h000004, 32'hC0A80001, OK);
  endtask

  task automatic test_strobe();
    axi_write(24'h000408, 32'h11223344, 4'hF, OK);
    axi_write(24'h000408, 32'h00FF0000, 4'h4, OK);
    axi_read(24'h000408, 32'h11FF3344, OK);
    axi_write(24'h000400, 32'h00000001, 4'h2, OK);
    axi_read(24'h000400, 32'h00000000, OK);
`ifndef IPFILTER_SHADOW_COMMIT_EN
    total++;
    if (rx_mask[31:0] !== 32'h11FF3344 || rx_vld[0] !== 1'b0) begin
      bad++;
      $display("FAIL strobe_output got mask=%h vld=%b want 11ff3344 0", rx_mask[31:0], rx_vld[0]);
    end
`endif
  endtask

  task automatic test_unmapped();
    axi_write(24'h000100, 32'hFFFFFFFF, 4'hF, ERR);
    axi_read(24'h00000C, 32'h0, ERR);
    axi_read(24'h000100, 32'h0, ERR);
    axi_write(24'h000800, 32'h00000001, 4'hF, ERR);
    axi_write(24'h00040C, 32'hFFFFFFFF, 4'hF, ERR);
    axi_read(24'h000810, 32'h0, ERR);
    axi_read(24'h001004, 32'h0, ERR);
    axi_read(24'h000000, 32'h0, OK);
    axi_read(24'h000004, 32'hC0A80001, OK);
    axi_read(24'h000408, 32'h11FF3344, OK);
  endtask

  task automatic test_read_hold();
    rexp_t e;
    tx_drop = 32'hDEADBEEF; rx_drop = 32'h12345678;
    step();
    axi_read(24'h00081C, 32'h02000010, OK);
    axi_read(24'h000804, 32'h12345678, OK);
    rd_q.push_back('{data: 32'hDEADBEEF, resp: OK});
    araddr = 24'h000800; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    tx_drop = 32'h00000000;
    e = rd_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp || arready !== 1'b0) begin
        bad++;
        $display("FAIL rd_hold cyc=%0d got rvalid=%b rdata=%h arready=%b want 1 %h 0",
                 i, rvalid, rdata, arready, e.data);
      end
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++;
      $display("FAIL rd_release got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_back_to_back();
    rexp_t re;
    logic [1:0] we;
    rd_q.push_back('{data: 32'hC0A80001, resp: OK});
    wr_q.push_back(OK);
    awaddr = 24'h000004; araddr = 24'h000004;
    wdata = 32'h0A000001; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    re = rd_q.pop_front();
    we = wr_q.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== re.data || bvalid !== 1'b1 || bresp !== we) begin
      bad++;
      $display("FAIL same_edge_rw got rvalid=%b rdata=%h bvalid=%b want 1 %h 1", rvalid, rdata, bvalid, re.data);
    end
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    axi_read(24'h000004, 32'h0A000001, OK);
    axi_write(24'h000444, 32'hAC100001, 4'hF, OK);
    axi_write(24'h000448, 32'hFFFF0000, 4'hF, OK);
    axi_read(24'h000444, 32'hAC100001, OK);
    axi_read(24'h000448, 32'hFFFF0000, OK);
  endtask

  task automatic test_commit();
    axi_write(24'h000030, 32'h00000001, 4'hF, OK);
    axi_write(24'h000034, 32'h0A0B0C0D, 4'hF, OK);
    axi_write(24'h000038, 32'hFFFFFF00, 4'hF, OK);
    axi_read(24'h000034, 32'h0A0B0C0D, OK);
`ifdef IPFILTER_SHADOW_COMMIT_EN
    begin
      logic [1:0] e;
      axi_write(24'h000810, 32'h00000000, 4'hF, OK);
      total++;
      if (tx_vld[3] !== 1'b0 || tx_addr[96 +: 32] !== 32'd0 || tx_mask[96 +: 32] !== 32'd0) begin
        bad++;
        $display("FAIL shadow_hidden got vld=%b addr=%h mask=%h want 0", tx_vld[3], tx_addr[96 +: 32], tx_mask[96 +: 32]);
      end
      wr_q.push_back(OK);
      awaddr = 24'h000810; wdata = 32'h00000001; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      e = wr_q.pop_front();
      total++;
      if (bvalid !== 1'b1 || bresp !== e || tx_vld[3] !== 1'b1 || tx_addr[96 +: 32] !== 32'h0A0B0C0D ||
          tx_mask[96 +: 32] !== 32'hFFFFFF00 || rx_mask[31:0] !== 32'h11FF3344) begin
        bad++;
        $display("FAIL commit_edge got bvalid=%b vld=%b addr=%h mask=%h want 1 1 0a0b0c0d ffffff00",
                 bvalid, tx_vld[3], tx_addr[96 +: 32], tx_mask[96 +: 32]);
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
    end
`else
    total++;
    if (tx_vld[3] !== 1'b1 || tx_addr[96 +: 32] !== 32'h0A0B0C0D || tx_mask[96 +: 32] !== 32'hFFFFFF00) begin
      bad++;
      $display("FAIL direct_out got vld=%b addr=%h mask=%h want 1 0a0b0c0d ffffff00",
               tx_vld[3], tx_addr[96 +: 32], tx_mask[96 +: 32]);
    end
    axi_write(24'h000810, 32'h00000001, 4'hF, OK);
    total++;
    if (tx_vld !== 16'h0008 || tx_addr[96 +: 32] !== 32'h0A0B0C0D) begin
      bad++;
      $display("FAIL commit_noeffect got vld=%h addr=%h want 0008 0a0b0c0d", tx_vld, tx_addr[96 +: 32]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    awaddr = 24'h000014; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    rst = 1'b1;
    #2;
    total++;
    if (bvalid !== 1'b0 || |{tx_vld, rx_vld, tx_addr, tx_mask, rx_addr, rx_mask} !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got bvalid=%b outputs_nonzero=%b want 0 0",
               bvalid, |{tx_vld, rx_vld, tx_addr, tx_mask, rx_addr, rx_mask});
    end
    wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    rst = 1'b0;
    step();
    total++;
    if ({awready, wready, arready} !== 3'b111 || bvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort got ready=%b bvalid=%b want 111 0", {awready, wready, arready}, bvalid);
    end
    axi_read(24'h000004, 32'h0, OK);
    axi_read(24'h000034, 32'h0, OK);
    axi_write(24'h000024, 32'h01020304, 4'hF, OK);
    axi_read(24'h000024, 32'h01020304, OK);
    axi_read(24'h000014, 32'h0, OK);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = 24'h0; araddr = 24'h0; awprot = 3'd0; arprot = 3'd0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; tx_drop = 32'h0; rx_drop = 32'h0;
    test_reset();
    test_split_write();
    test_strobe();
    test_unmapped();
    test_read_hold();
    test_back_to_back();
    test_commit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
